bcd_mod_counter: RTL and testbench

Parametrised two-digit BCD modulo counter for the clock datapath; the general successor to the fixed mod-60 seconds stage. One instance serves as seconds/minutes (MODULUS=60), hours (MODULUS=24) or any mod-N stage up to 100. Adds over the previous generation:
- count enable for cascading
- up/down mode with borrow
- validated parallel load with error flag
- synchronous reset to a parametrised value
- carry coincident with the wrap

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_digit.sv | 29 ++
 rtl/bcd_mod_counter.sv | 96 +++++++++
 tb/tb_bcd_mod_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared helpers for the BCD modulo counter: digit splits and validity.
package bcd_pkg;

  // High digit of the terminal count (MODULUS-1).
  function automatic logic [3:0] max_h(input int modulus);
    return 4'((modulus - 1) / 10);
  endfunction

  // Low digit of the terminal count (MODULUS-1).
  function automatic logic [3:0] max_l(input int modulus);
    return 4'((modulus - 1) % 10);
  endfunction

  // High digit of the reset value.
  function automatic logic [3:0] init_h(input int init);
    return 4'(init / 10);
  endfunction

  // Low digit of the reset value.
  function automatic logic [3:0] init_l(input int init);
    return 4'(init % 10);
  endfunction

  // A 4-bit code is a legal BCD digit when it is 0..9.
  function automatic logic bcd_valid(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with 0..9 wrap and ripple flags.
module bcd_digit #(
  parameter logic [3:0] RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] value,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  assign at_max = (digit == 4'd9);
  assign at_min = (digit == 4'd0);

  // Digit register: reset > load > tick; ticks wrap inside 0..9.
  always_ff @(posedge clk) begin
    if (rst)       digit <= RST_VAL;
    else if (load) digit <= value;
    else if (tick) begin
      if (up) digit <= at_max ? 4'd0 : digit + 4'd1;
      else    digit <= at_min ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-N counter with enable, up/down, checked load and
// a wrap pulse that lands on the same edge as the wrapped value.
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int INIT    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_h,
  input  logic [3:0] load_l,
  output logic [3:0] cnt_h,
  output logic [3:0] cnt_l,
  output logic       carry,
  output logic       load_err
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS must be in 2..100");
  end
  if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
    $error("bcd_mod_counter: INIT must be in 0..MODULUS-1");
  end

  localparam logic [3:0] MAX_H  = max_h(MODULUS);
  localparam logic [3:0] MAX_L  = max_l(MODULUS);
  localparam logic [3:0] INIT_H = init_h(INIT);
  localparam logic [3:0] INIT_L = init_l(INIT);

  logic       h_at_min, l_at_max, l_at_min;
  logic       unused_h_at_max;
  logic       term_up, term_dn, count, wrap;
  logic [7:0] ld_val;
  logic       ld_ok, dig_load, tick_h;
  logic [3:0] val_h, val_l;

  // Terminal counts in each direction.
  assign term_up = (cnt_h == MAX_H) && (cnt_l == MAX_L);
  assign term_dn = h_at_min && l_at_min;

  // A load cycle never counts, so en only matters without load.
  assign count = en && !load;
  assign wrap  = count && (up ? term_up : term_dn);

  // Load value must be two legal digits and below the modulus.
  assign ld_val = 8'(load_h) * 8'd10 + 8'(load_l);
  assign ld_ok  = bcd_valid(load_h) && bcd_valid(load_l) && (ld_val < 8'(MODULUS));

  // Modulus wrap reuses the digit load path: 00 going up, MODULUS-1 going down.
  assign dig_load = (load && ld_ok) || wrap;
  assign val_h    = load ? load_h : (up ? 4'd0 : MAX_H);
  assign val_l    = load ? load_l : (up ? 4'd0 : MAX_L);

  // High digit moves only when the low digit rolls over.
  assign tick_h = count && (up ? l_at_max : l_at_min);

  bcd_digit #(.RST_VAL(INIT_L)) u_lo (
    .clk    (clk),
    .rst    (rst),
    .tick   (count),
    .up     (up),
    .load   (dig_load),
    .value  (val_l),
    .digit  (cnt_l),
    .at_max (l_at_max),
    .at_min (l_at_min)
  );

  bcd_digit #(.RST_VAL(INIT_H)) u_hi (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick_h),
    .up     (up),
    .load   (dig_load),
    .value  (val_h),
    .digit  (cnt_h),
    .at_max (unused_h_at_max),
    .at_min (h_at_min)
  );

  // Registered wrap pulse and load-reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= wrap;
      load_err <= load && !ld_ok;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Random + directed bench for bcd_mod_counter against an integer model.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared stimulus for the three single-stage instances.
  logic       rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] lh = 4'd0, ll = 4'd0;

  logic [3:0] a_h, a_l, b_h, b_l, c_h, c_l;
  logic       a_cy, a_er, b_cy, b_er, c_cy, c_er;

  bcd_mod_counter #(.MODULUS(60), .INIT(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_h(lh), .load_l(ll),
    .cnt_h(a_h), .cnt_l(a_l), .carry(a_cy), .load_err(a_er));
  bcd_mod_counter #(.MODULUS(24), .INIT(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_h(lh), .load_l(ll),
    .cnt_h(b_h), .cnt_l(b_l), .carry(b_cy), .load_err(b_er));
  bcd_mod_counter #(.MODULUS(60), .INIT(58)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_h(lh), .load_l(ll),
    .cnt_h(c_h), .cnt_l(c_l), .carry(c_cy), .load_err(c_er));

  // Cascaded minutes:seconds pair.
  logic       crst = 1'b1, cen = 1'b0;
  logic [3:0] s_h, s_l, m_h, m_l;
  logic       s_cy, s_er, m_cy, m_er;

  bcd_mod_counter #(.MODULUS(60), .INIT(0)) u_sec (
    .clk(clk), .rst(crst), .en(cen), .up(1'b1), .load(1'b0), .load_h(4'd0), .load_l(4'd0),
    .cnt_h(s_h), .cnt_l(s_l), .carry(s_cy), .load_err(s_er));
  bcd_mod_counter #(.MODULUS(60), .INIT(0)) u_min (
    .clk(clk), .rst(crst), .en(s_cy), .up(1'b1), .load(1'b0), .load_h(4'd0), .load_l(4'd0),
    .cnt_h(m_h), .cnt_l(m_l), .carry(m_cy), .load_err(m_er));

  // Model state: plain integer counts and expected pulses.
  int ma, mb, mc;
  bit acy, aer, bcy, ber, ccy, cer;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One edge of a mod-m counter, from the behavioural rules.
  task automatic model(input int m, input int init, input bit r, input bit l,
                       input int h, input int lo, input bit e, input bit u,
                       inout int c, output bit cy, output bit er);
    cy = 0; er = 0;
    if (r) c = init;
    else if (l) begin
      if (h <= 9 && lo <= 9 && h * 10 + lo < m) c = h * 10 + lo;
      else er = 1;
    end else if (e) begin
      if (u) begin
        if (c == m - 1) begin c = 0; cy = 1; end
        else c = c + 1;
      end else begin
        if (c == 0) begin c = m - 1; cy = 1; end
        else c = c - 1;
      end
    end
  endtask

  task automatic chk_dut(input string n, input logic [3:0] h, input logic [3:0] l,
                         input logic cy, input logic er, input int m, input bit ecy, input bit eer);
    chk({n, "_h"}, int'(h), m / 10);
    chk({n, "_l"}, int'(l), m % 10);
    chk({n, "_carry"}, int'(cy), int'(ecy));
    chk({n, "_err"}, int'(er), int'(eer));
  endtask

  task automatic step(input bit r, input bit l, input int h, input int lo, input bit e, input bit u);
    @(negedge clk);
    rst = r; load = l; lh = 4'(h); ll = 4'(lo); en = e; up = u;
    @(posedge clk);
    model(60, 0,  r, l, h, lo, e, u, ma, acy, aer);
    model(24, 0,  r, l, h, lo, e, u, mb, bcy, ber);
    model(60, 58, r, l, h, lo, e, u, mc, ccy, cer);
    #1;
    chk_dut("a", a_h, a_l, a_cy, a_er, ma, acy, aer);
    chk_dut("b", b_h, b_l, b_cy, b_er, mb, bcy, ber);
    chk_dut("c", c_h, c_l, c_cy, c_er, mc, ccy, cer);
  endtask

  initial begin
    // Reset state.
    step(1, 0, 0, 0, 0, 1);
    chk("rst_a", int'(a_h) * 10 + int'(a_l), 0);
    chk("rst_c", int'(c_h) * 10 + int'(c_l), 58);

    // 60 up-ticks on mod 60: 01..59 then 00 with carry.
    for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 1, 1);
    chk("wrap60_val", int'(a_h) * 10 + int'(a_l), 0);
    chk("wrap60_cy", int'(a_cy), 1);

    // Mod 24: load 23, tick up -> 00 carry, tick down -> 23 borrow.
    step(0, 1, 2, 3, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("m24_up_val", int'(b_h) * 10 + int'(b_l), 0);
    chk("m24_up_cy", int'(b_cy), 1);
    step(0, 0, 0, 0, 1, 0);
    chk("m24_dn_val", int'(b_h) * 10 + int'(b_l), 23);
    chk("m24_dn_cy", int'(b_cy), 1);

    // Invalid and valid loads on mod 60.
    step(0, 1, 6, 0, 0, 1);
    chk("ld60_err", int'(a_er), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ld_err_clear", int'(a_er), 0);
    step(0, 1, 3, 12, 0, 1);
    chk("ld3_12_err", int'(a_er), 1);
    step(0, 1, 5, 9, 0, 1);
    chk("ld59_val", int'(a_h) * 10 + int'(a_l), 59);
    chk("ld59_err", int'(a_er), 0);

    // Load beats a simultaneous tick.
    step(0, 1, 4, 2, 0, 1);
    step(0, 1, 3, 7, 1, 1);
    chk("ld_en_val", int'(a_h) * 10 + int'(a_l), 37);
    chk("ld_en_cy", int'(a_cy), 0);

    // Reset beats a tick at 59; INIT=58 instance then counts 59, 00.
    step(0, 1, 5, 9, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    chk("rst_en_a", int'(a_h) * 10 + int'(a_l), 0);
    chk("rst_en_cy", int'(a_cy), 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("init58_wrap", int'(c_h) * 10 + int'(c_l), 0);
    chk("init58_cy", int'(c_cy), 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit r, l, e, u;
      int h, lo;
      r = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) begin h = $urandom_range(0, 6); lo = $urandom_range(0, 9); end
      else begin h = $urandom_range(0, 15); lo = $urandom_range(0, 15); end
      step(r, l, h, lo, e, u);
    end
    step(0, 0, 0, 0, 0, 1);

    // Cascade: 3600 ticks from 00:00 plus one settle edge.
    begin
      int sec_m, min_m, min_pulses;
      bit sec_cy_m, min_cy_m, min_en;
      @(negedge clk); crst = 1'b1; cen = 1'b0;
      @(posedge clk); #1;
      chk("casc_rst", int'(m_h) * 1000 + int'(m_l) * 100 + int'(s_h) * 10 + int'(s_l), 0);
      sec_m = 0; min_m = 0; sec_cy_m = 0; min_cy_m = 0; min_pulses = 0;
      for (int t = 0; t < 3601; t++) begin
        @(negedge clk); crst = 1'b0; cen = (t < 3600);
        @(posedge clk);
        min_en = sec_cy_m;
        sec_cy_m = 0; min_cy_m = 0;
        if (min_en) begin
          if (min_m == 59) begin min_m = 0; min_cy_m = 1; end else min_m++;
        end
        if (t < 3600) begin
          if (sec_m == 59) begin sec_m = 0; sec_cy_m = 1; end else sec_m++;
        end
        #1;
        if (m_cy) min_pulses++;
        chk("casc_sec", int'(s_h) * 10 + int'(s_l), sec_m);
        chk("casc_min", int'(m_h) * 10 + int'(m_l), min_m);
        chk("casc_scy", int'(s_cy), int'(sec_cy_m));
        chk("casc_mcy", int'(m_cy), int'(min_cy_m));
        if (t == 3598)
          chk("casc_5959", int'(m_h) * 1000 + int'(m_l) * 100 + int'(s_h) * 10 + int'(s_l), 5959);
      end
      chk("casc_final", int'(m_h) * 1000 + int'(m_l) * 100 + int'(s_h) * 10 + int'(s_l), 0);
      chk("casc_pulses", min_pulses, 1);
      chk("casc_err", int'(s_er) + int'(m_er), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
